// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: widths, opcodes, sequencer states and flag bundle.
package alu_defs_pkg;

    localparam int unsigned ALU_W = 16;
    localparam int unsigned OP_W  = 3;

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_NOT = 3'b101,
        ALU_SHL = 3'b110,
        ALU_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_WAIT_B = 2'b01,
        ST_EXEC   = 2'b10,
        ST_HOLD   = 2'b11
    } seq_state_e;

    typedef struct packed {
        logic z;
        logic n;
        logic c;
        logic v;
    } alu_flags_t;

    // NOT, SHL and SHR consume only the A word.
    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == ALU_NOT) || (op == ALU_SHL) || (op == ALU_SHR);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational 16-bit ALU: result plus zero/negative/carry/overflow flags.
module alu_core
    import alu_defs_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [ALU_W-1:0] res,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             v
);

    logic [ALU_W:0] sum_ext;
    logic [ALU_W:0] diff_ext;

    // Subtraction as A + ~B + 1; the carry-out is the inverse of the borrow.
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} + {1'b0, ~b} + (ALU_W+1)'(1);

    // Result, carry and overflow selection per opcode.
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (op)
            ALU_ADD: begin
                res = sum_ext[ALU_W-1:0];
                c   = sum_ext[ALU_W];
                v   = (a[ALU_W-1] == b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_SUB: begin
                res = diff_ext[ALU_W-1:0];
                c   = ~diff_ext[ALU_W];
                v   = (a[ALU_W-1] != b[ALU_W-1]) && (res[ALU_W-1] != a[ALU_W-1]);
            end
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_XOR: res = a ^ b;
            ALU_NOT: res = ~a;
            ALU_SHL: begin
                res = {a[ALU_W-2:0], 1'b0};
                c   = a[ALU_W-1];
            end
            ALU_SHR: begin
                res = {1'b0, a[ALU_W-1:1]};
                c   = a[0];
            end
            default: res = '0;
        endcase
    end

    assign z = (res == '0);
    assign n = res[ALU_W-1];

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle ALU initiator: collects opcode/A (and B for binary ops) from a
// shared valid/ready bus, executes for one cycle, holds the result until taken.
module alu_op_sequencer
    import alu_defs_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [ALU_W-1:0] bus_in,
    input  logic [OP_W-1:0]  op_in,
    input  logic             bus_valid,
    output logic             bus_ready,
    output logic [ALU_W-1:0] res_out,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             res_valid,
    input  logic             res_ready
);

    seq_state_e       state_q, state_d;
    logic [ALU_W-1:0] a_q, a_d;
    logic [ALU_W-1:0] b_q, b_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [ALU_W-1:0] res_q, res_d;
    alu_flags_t       flags_q, flags_d;
    logic             bus_ready_q, bus_ready_d;
    logic             res_valid_q, res_valid_d;

    logic [ALU_W-1:0] core_res;
    alu_flags_t       core_flags;

    alu_core u_alu_core (
        .a   (a_q),
        .b   (b_q),
        .op  (op_q),
        .res (core_res),
        .z   (core_flags.z),
        .n   (core_flags.n),
        .c   (core_flags.c),
        .v   (core_flags.v)
    );

    // Next-state, operand capture and result capture.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_valid) begin
                    a_d     = bus_in;
                    op_d    = op_in;
                    state_d = is_unary(op_in) ? ST_EXEC : ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bus_valid) begin
                    b_d     = bus_in;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                res_d   = core_res;
                flags_d = core_flags;
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        bus_ready_d = (state_d == ST_IDLE) || (state_d == ST_WAIT_B);
        res_valid_d = (state_d == ST_HOLD);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            bus_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            res_q       <= res_d;
            flags_q     <= flags_d;
            bus_ready_q <= bus_ready_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus_ready = bus_ready_q;
    assign res_valid = res_valid_q;
    assign res_out   = res_q;
    assign flag_z    = flags_q.z;
    assign flag_n    = flags_q.n;
    assign flag_c    = flags_q.c;
    assign flag_v    = flags_q.v;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: directed cases plus random ops
// against an arithmetic reference model.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic [15:0] bus_in;
    logic [2:0]  op_in;
    logic        bus_valid;
    logic        bus_ready;
    logic [15:0] res_out;
    logic        flag_z, flag_n, flag_c, flag_v;
    logic        res_valid;
    logic        res_ready;

    int checks = 0;
    int errors = 0;

    alu_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus_in    (bus_in),
        .op_in     (op_in),
        .bus_valid (bus_valid),
        .bus_ready (bus_ready),
        .res_out   (res_out),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .res_valid (res_valid),
        .res_ready (res_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: {res[15:0], z, n, c, v} from integer arithmetic.
    function automatic logic [19:0] ref_alu(input int op, input int a, input int b);
        int r, sa, sb, s;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        case (op)
            0: begin
                r = (a + b) % 65536;
                c = (a + b) > 65535;
                s = sa + sb;
                v = (s > 32767) || (s < -32768);
            end
            1: begin
                r = (a - b + 65536) % 65536;
                c = a < b;
                s = sa - sb;
                v = (s > 32767) || (s < -32768);
            end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 65535 - a;
            6: begin
                r = (a * 2) % 65536;
                c = a >= 32768;
            end
            default: begin
                r = a / 2;
                c = (a % 2) == 1;
            end
        endcase
        ref_alu = {16'(r), (r == 0), (r >= 32768), c, v};
    endfunction

    function automatic logic [19:0] observed();
        return {res_out, flag_z, flag_n, flag_c, flag_v};
    endfunction

    task automatic check_reset_state(input string tag);
        chk(tag, {bus_ready, res_valid, observed()}, {1'b1, 1'b0, 20'h0});
    endtask

    // Present the current bus word until accepted, bounded.
    task automatic wait_accept(input string tag);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = bus_ready;
            step();
            n++;
        end
        chk(tag, 32'(acc), 32'd1);
    endtask

    // One full operation; optionally parks the next bus word during EXEC/HOLD,
    // and optionally resets while the result is held instead of consuming it.
    task automatic do_op(input int op, input int a, input int b, input int gap,
                         input int stall, input logic nv, input int na, input int nop,
                         input logic rst_hold);
        logic [19:0] exp;
        bus_valid = 1'b1;
        bus_in    = 16'(a);
        op_in     = 3'(op);
        wait_accept("accept_a");
        if (op <= 4) begin
            bus_valid = 1'b0;
            for (int i = 0; i < gap; i++) begin
                chk("wait_b_ready", 32'(bus_ready), 32'd1);
                step();
            end
            bus_valid = 1'b1;
            bus_in    = 16'(b);
            op_in     = 3'($urandom_range(0, 7));
            wait_accept("accept_b");
        end
        bus_valid = nv;
        bus_in    = 16'(na);
        op_in     = 3'(nop);
        chk("exec_state", {res_valid, bus_ready}, 2'b00);
        step();
        exp = ref_alu(op, a, b);
        chk("res_valid_rise", 32'(res_valid), 32'd1);
        chk("result_flags", observed(), exp);
        if (rst_hold) begin
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            check_reset_state("reset_in_hold");
            return;
        end
        for (int i = 0; i < stall; i++) begin
            res_ready = 1'b0;
            step();
            chk("hold_stable", {res_valid, bus_ready, observed()}, {1'b1, 1'b0, exp});
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("idle_after_take", {res_valid, bus_ready}, 2'b01);
    endtask

    initial begin
        rst_n     = 1'b0;
        bus_in    = '0;
        op_in     = '0;
        bus_valid = 1'b0;
        res_ready = 1'b0;
        step();
        step();
        check_reset_state("reset_values");
        rst_n = 1'b1;
        step();

        do_op(4, 16'hA5A5, 16'hFFFF, 0, 0, 1'b0, 0, 0, 1'b0);
        do_op(0, 16'hFFFF, 16'h0001, 1, 0, 1'b0, 0, 0, 1'b0);
        do_op(0, 16'h7FFF, 16'h0001, 0, 1, 1'b0, 0, 0, 1'b0);
        do_op(1, 16'h8000, 16'h0001, 2, 0, 1'b0, 0, 0, 1'b0);
        do_op(1, 16'h0001, 16'h0002, 0, 0, 1'b0, 0, 0, 1'b0);
        // Unary SHL with the next word already on the bus; it must become next A.
        do_op(6, 16'h8001, 16'h0000, 0, 2, 1'b1, 16'h1234, 7, 1'b0);
        do_op(7, 16'h1234, 16'h0000, 0, 0, 1'b0, 0, 0, 1'b0);
        // Backpressure for five cycles.
        do_op(2, 16'hF0F0, 16'h3C3C, 0, 5, 1'b0, 0, 0, 1'b0);

        // Reset while waiting for B.
        bus_valid = 1'b1;
        bus_in    = 16'h1111;
        op_in     = 3'd0;
        wait_accept("accept_a_pre_reset");
        bus_valid = 1'b0;
        rst_n     = 1'b0;
        step();
        rst_n = 1'b1;
        check_reset_state("reset_in_wait_b");
        do_op(3, 16'h00F0, 16'h0F00, 0, 0, 1'b0, 0, 0, 1'b0);

        // Reset while holding a result, then a fresh op.
        do_op(5, 16'h00FF, 16'h0000, 0, 0, 1'b0, 0, 0, 1'b1);
        do_op(0, 16'h1234, 16'h4321, 0, 0, 1'b0, 0, 0, 1'b0);

        // Random operations with random B gaps and result backpressure.
        for (int t = 0; t < 200; t++) begin
            do_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)),
                  int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)), 1'b0, 0, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
